// File: rtl/ysyx_210978_booth_mul_iter_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM state encodings, Booth select codes and the recoding table.
package ysyx_210978_booth_mul_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_POS  = 3'd1,
      SEL_DPOS = 3'd2,
      SEL_NEG  = 3'd3,
      SEL_DNEG = 3'd4
   } booth_sel_t;

   // Triplet {y[2k+1], y[2k], y[2k-1]} -> digit in {-2,-1,0,+1,+2}
   function automatic booth_sel_t booth_decode(input logic [2:0] y);
      booth_sel_t sel;
      case (y)
         3'b001, 3'b010: sel = SEL_POS;
         3'b011:         sel = SEL_DPOS;
         3'b100:         sel = SEL_DNEG;
         3'b101, 3'b110: sel = SEL_NEG;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/ysyx_210978_booth_sel.sv
// Booth partial-product selector: returns X, 2X or their bitwise inverse,
// with neg flagging the +1 that completes the two's-complement negation.
module ysyx_210978_booth_sel
   import ysyx_210978_booth_mul_iter_pkg::*;
#(
   parameter int W = 65
) (
   input  logic [2:0]   y_in,
   input  logic [W-1:0] x_in,
   output logic [W:0]   pp,
   output logic         neg
);

   booth_sel_t sel;
   logic [W:0] x1;
   logic [W:0] x2;

   assign sel = booth_decode(y_in);
   assign x1  = {x_in[W-1], x_in};
   assign x2  = {x_in, 1'b0};

   always_comb begin
      pp  = '0;
      neg = 1'b0;
      case (sel)
         SEL_POS:  pp = x1;
         SEL_DPOS: pp = x2;
         SEL_NEG: begin
            pp  = ~x1;
            neg = 1'b1;
         end
         SEL_DNEG: begin
            pp  = ~x2;
            neg = 1'b1;
         end
         default: begin
            pp  = '0;
            neg = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_210978_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle, full
// 2*XLEN product for any signedness combination, valid/ready on both sides.
module ysyx_210978_booth_mul_iter
   import ysyx_210978_booth_mul_iter_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*XLEN-1:0] product,
   output state_t            state_dbg
);

   localparam int N_ITER = (XLEN + 2) / 2;
   localparam int CNT_W  = $clog2(N_ITER + 1);
   localparam int A_W    = XLEN + 1;
   localparam int B_W    = XLEN + 3;
   localparam int PP_W   = XLEN + 2;
   localparam int ACC_W  = 2 * XLEN + 2;
   localparam int SH_W   = CNT_W + 1;

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [A_W-1:0]     a_q;
   logic [B_W-1:0]     b_q;
   logic [ACC_W-1:0]   acc;
   logic [PP_W-1:0]    pp;
   logic               neg;
   logic [SH_W-1:0]    sh;
   logic [ACC_W-1:0]   pp_ext;
   logic [ACC_W-1:0]   fill;
   logic [ACC_W-1:0]   addend;
   logic [ACC_W-1:0]   sum;
   logic               accept;
   logic               last_iter;

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // in_ready is high only in IDLE and is masked by flush; out_valid is high
   // in DONE and holds, with product stable, until out_ready, flush or reset.
   assign in_ready  = (state == ST_IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == ST_DONE);
   assign last_iter = (cnt == CNT_W'(N_ITER - 1));
   assign product   = acc[2*XLEN-1:0];
   assign state_dbg = state;

   // b_q shifts right by two each iteration, so the current triplet is b_q[2:0].
   ysyx_210978_booth_sel #(
      .W(A_W)
   ) u_booth_sel (
      .y_in (b_q[2:0]),
      .x_in (a_q),
      .pp   (pp),
      .neg  (neg)
   );

   // Negation of X<<2k equals (~X<<2k) with ones filled in the low 2k bits, plus 1,
   // so the +1 lands on the LSB carry-in of the single accumulator adder.
   assign sh     = {cnt, 1'b0};
   assign pp_ext = {{XLEN{pp[PP_W-1]}}, pp};
   assign fill   = neg ? ~({ACC_W{1'b1}} << sh) : '0;
   assign addend = (pp_ext << sh) | fill;
   assign sum    = acc + addend + ACC_W'(neg);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (accept)    state_nx = ST_BUSY;
         ST_BUSY: if (last_iter) state_nx = ST_DONE;
         ST_DONE: if (out_ready) state_nx = ST_IDLE;
         default:                state_nx = ST_IDLE;
      endcase
      if (flush) begin
         state_nx = ST_IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
         a_q <= '0;
         b_q <= '0;
         acc <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
         acc <= '0;
         a_q <= {a_signed & op_a[XLEN-1], op_a};
         b_q <= {{2{b_signed & op_b[XLEN-1]}}, op_b, 1'b0};
      end else if (state == ST_BUSY) begin
         cnt <= cnt + 1'b1;
         acc <= sum;
         b_q <= b_q >> 2;
      end
   end

endmodule

// File: tb/tb_ysyx_210978_booth_mul_iter.sv
// Bench for the iterative Booth multiplier: directed corner ops, backpressure,
// flush and reset cases, then randomized traffic against a plain-arithmetic model.
module tb_ysyx_210978_booth_mul_iter;
   import ysyx_210978_booth_mul_iter_pkg::*;

   localparam int XLEN   = 64;
   localparam int PW     = 2 * XLEN;
   localparam int N_ITER = (XLEN + 2) / 2;
   localparam int N_RAND = 400;

   logic            clock = 1'b0;
   logic            reset;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            a_signed;
   logic            b_signed;
   logic            out_valid;
   logic            out_ready;
   logic [PW-1:0]   product;
   state_t          state_dbg;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [PW-1:0]   exp_q[$];

   ysyx_210978_booth_mul_iter #(.XLEN(XLEN)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .a_signed  (a_signed),
      .b_signed  (b_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking and reference model ----------------
   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic as, input logic bs);
      logic signed [PW:0] ea;
      logic signed [PW:0] eb;
      logic signed [PW:0] p;
      ea = {{(PW + 1 - XLEN){as & a[XLEN-1]}}, a};
      eb = {{(PW + 1 - XLEN){bs & b[XLEN-1]}}, b};
      p  = ea * eb;
      return p[PW-1:0];
   endfunction

   function automatic logic [XLEN-1:0] rand_operand();
      logic [XLEN-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(XLEN - 1){1'b0}}};
         3:       v = {1'b0, {(XLEN - 1){1'b1}}};
         4:       v = XLEN'(1);
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, PW'(in_ready), PW'(1));
   endtask

   // Present one op for one edge; return the number of edges until out_valid.
   task automatic launch(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic as, input logic bs, input logic ordy,
                         input string tag, output int lat);
      wait_ready(tag);
      op_a      = a;
      op_b      = b;
      a_signed  = as;
      b_signed  = bs;
      out_ready = ordy;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      op_a     = {$urandom, $urandom};
      op_b     = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic as, input logic bs, input logic [PW-1:0] exp,
                        input string tag);
      int lat;
      launch(a, b, as, bs, 1'b1, tag, lat);
      check({tag, "_lat"}, PW'(lat), PW'(N_ITER));
      check(tag, product, exp);
      tick();
      check({tag, "_done"}, PW'(out_valid), PW'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int            lat;
      int            age;
      int            done_ops;
      int            cyc;
      logic          seen;
      logic          exp_ov;
      logic          fire_in;
      logic          fire_out;
      logic [PW-1:0] exp;

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      a_signed  = 1'b0;
      b_signed  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_in_ready",  PW'(in_ready),  PW'(1));
      check("rst_out_valid", PW'(out_valid), PW'(0));
      check("rst_product",   product,        '0);
      check("rst_state",     PW'(state_dbg), PW'(ST_IDLE));

      // Directed corners
      do_op('1, '1, 1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "uxu_ones");
      do_op('1, '1, 1'b1, 1'b1, 128'h1, "sxs_m1");
      do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
            128'h4000_0000_0000_0000_0000_0000_0000_0000, "sxs_min");
      do_op('1, 64'd2, 1'b1, 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, "sxu_m1x2");
      do_op(64'd0, '1, 1'b1, 1'b1, 128'h0, "zero");

      // Backpressure: five cycles with out_ready low after out_valid
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
      exp  = ref_mul(op_a, op_b, 1'b1, 1'b1);
      launch(op_a, op_b, 1'b1, 1'b1, 1'b0, "bp", lat);
      check("bp_lat", PW'(lat), PW'(N_ITER));
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", PW'(out_valid), PW'(1));
         check("bp_product",   product,        exp);
         check("bp_in_ready",  PW'(in_ready),  PW'(0));
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_product_hs", product, exp);
      tick();
      check("bp_after_valid", PW'(out_valid), PW'(0));
      check("bp_after_ready", PW'(in_ready),  PW'(1));

      // Flush at BUSY cycle 10 with a competing in_valid
      launch_flush: begin
         wait_ready("fl");
         op_a     = 64'd123456789;
         op_b     = 64'd987654321;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         repeat (10) tick();
         flush    = 1'b1;
         in_valid = 1'b1;
         op_a     = 64'd11;
         op_b     = 64'd13;
         #1;
         check("fl_in_ready_during", PW'(in_ready), PW'(0));
         tick();
         flush    = 1'b0;
         in_valid = 1'b0;
         #1;
         check("fl_out_valid", PW'(out_valid), PW'(0));
         check("fl_in_ready",  PW'(in_ready),  PW'(1));
         seen = 1'b0;
         for (int i = 0; i < N_ITER + 5; i++) begin
            tick();
            seen = seen | out_valid;
         end
         check("fl_no_valid", PW'(seen), PW'(0));
      end
      do_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, "fl_next");

      // Reset pulse mid-BUSY
      wait_ready("rb");
      op_a     = 64'hDEAD_BEEF_0123_4567;
      op_b     = 64'h0F0F_F0F0_1234_5678;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("rb_in_ready",  PW'(in_ready),  PW'(1));
      check("rb_out_valid", PW'(out_valid), PW'(0));
      check("rb_product",   product,        '0);
      do_op(64'd3, 64'd5, 1'b0, 1'b0, 128'd15, "rb_next");

      // Randomized traffic with backpressure and occasional flush
      exp_q.delete();
      age      = 0;
      done_ops = 0;
      cyc      = 0;
      while (done_ops < N_RAND && cyc < 60000) begin
         flush     = ($urandom_range(0, 199) == 0);
         in_valid  = $urandom_range(0, 1) != 0;
         op_a      = rand_operand();
         op_b      = rand_operand();
         a_signed  = $urandom_range(0, 1) != 0;
         b_signed  = $urandom_range(0, 1) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         exp_ov = (exp_q.size() != 0) && (age >= N_ITER);
         check("rnd_in_ready",  PW'(in_ready),  PW'((exp_q.size() == 0) && !flush));
         check("rnd_out_valid", PW'(out_valid), PW'(exp_ov));
         if (exp_ov) check("rnd_product", product, exp_q[0]);
         fire_in  = in_valid && (exp_q.size() == 0) && !flush;
         fire_out = exp_ov && out_ready;
         if (fire_in) exp = ref_mul(op_a, op_b, a_signed, b_signed);
         tick();
         if (exp_q.size() != 0) age++;
         if (fire_out) begin
            void'(exp_q.pop_front());
            done_ops++;
         end else if (flush && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            done_ops++;
         end
         if (fire_in) begin
            exp_q.push_back(exp);
            age = 0;
         end
         cyc++;
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rnd_ops_done", PW'(done_ops), PW'(N_RAND));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
